// File: rtl/hbf_pkg.sv
// Shared widths, halfband coefficients and FSM state type for the 2:1 halfband decimator.
package hbf_pkg;

    localparam int unsigned DW = 18;
    localparam int unsigned CW = 18;
    localparam int unsigned AW = 40;

    // Q1.17 taps; odd taps other than the centre are zero, DC gain is exactly 1.0
    localparam logic signed [CW-1:0] C0   = 18'sd1638;
    localparam logic signed [CW-1:0] C2   = -18'sd9830;
    localparam logic signed [CW-1:0] C4   = 18'sd40960;
    localparam logic signed [CW-1:0] CCTR = 18'sd65536;

    // Centre tap is a power of two, so it is applied as a shift rather than a multiply
    localparam int unsigned CSH = $clog2(CCTR);

    typedef enum logic [3:0] {IDLE, MX0, MX1, MX2, OX, MY0, MY1, MY2, OY} state_t;

    function automatic logic signed [CW-1:0] coef(input logic [1:0] k);
        case (k)
            2'd0:    return C0;
            2'd1:    return C2;
            default: return C4;
        endcase
    endfunction

endpackage

// File: rtl/hbf_dec2x2_if.sv
// Sample stream from the CIC into the halfband decimator and the filtered stream out.
interface hbf_dec2x2_if;
    import hbf_pkg::*;

    logic signed [DW-1:0] din;
    logic                 div;
    logic                 ce;
    logic signed [DW-1:0] dout;
    logic                 dov;
    logic                 dch;
    logic                 ovf;
    logic                 orun;

    modport master (output din, div, ce, input dout, dov, dch, ovf, orun);
    modport slave  (input din, div, ce, output dout, dov, dch, ovf, orun);

endinterface

// File: rtl/hbf_mac.sv
// Single-multiplier datapath: symmetric pre-add, multiply-accumulate, centre tap, round, saturate.
module hbf_mac
    import hbf_pkg::*;
(
    input  logic                 dclk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 fin,
    input  logic [1:0]           csel,
    input  logic signed [DW-1:0] da,
    input  logic signed [DW-1:0] db,
    input  logic signed [DW-1:0] dc,
    output logic signed [DW-1:0] dout,
    output logic                 ovf
);

    localparam int unsigned PW = DW + 1 + CW;
    localparam int unsigned RSH = CW - 1;
    localparam logic signed [AW-1:0] HALF = AW'(1) <<< (RSH - 1);
    localparam logic signed [AW-1:0] SMAX = (AW'(1) <<< (DW - 1)) - AW'(1);
    localparam logic signed [AW-1:0] SMIN = ~SMAX;

    logic signed [DW:0]   pre;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] prod_x;
    logic signed [AW-1:0] ctr_x;
    logic signed [AW-1:0] s;
    logic signed [AW-1:0] r;
    logic signed [AW-1:0] acc_q;
    logic signed [DW-1:0] sat;
    logic                 sat_hit;

    always_comb begin
        pre    = $signed({da[DW-1], da}) + $signed({db[DW-1], db});
        prod   = PW'(pre) * PW'(coef(csel));
        prod_x = AW'(prod);
        ctr_x  = AW'(dc) <<< CSH;
        // Adding half an LSB before the arithmetic shift rounds half up
        s      = acc_q + ctr_x + HALF;
        r      = s >>> RSH;
        sat_hit = 1'b1;
        if (r > SMAX) begin
            sat = SMAX[DW-1:0];
        end else if (r < SMIN) begin
            sat = SMIN[DW-1:0];
        end else begin
            sat     = r[DW-1:0];
            sat_hit = 1'b0;
        end
    end

    always_ff @(posedge dclk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
            dout  <= '0;
            ovf   <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (clr) begin
                acc_q <= prod_x;
            end else if (en) begin
                acc_q <= acc_q + prod_x;
            end
            if (fin) begin
                dout <= sat;
                ovf  <= sat_hit;
            end
        end
    end

endmodule

// File: rtl/hbf_dec2x2.sv
// 11-tap halfband decimate-by-2 on interleaved x/y channels: delay lines, phase, sequencing FSM.
module hbf_dec2x2
    import hbf_pkg::*;
(
    input  logic        dclk,
    input  logic        rstn,
    hbf_dec2x2_if.slave bus
);

    localparam int unsigned NT = 11;

    logic signed [DW-1:0] dx [NT];
    logic signed [DW-1:0] dy [NT];
    state_t               state;
    logic                 ph;
    logic                 start;
    logic                 dov;
    logic                 dch;
    logic                 orun;
    logic                 clr;
    logic                 en;
    logic                 fin;
    logic                 chy;
    logic [1:0]           k;
    logic signed [DW-1:0] da;
    logic signed [DW-1:0] db;
    logic signed [DW-1:0] dc;
    logic signed [DW-1:0] dout;
    logic                 ovf;

    always_ff @(posedge dclk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NT; i++) begin
                dx[i] <= '0;
                dy[i] <= '0;
            end
            state <= IDLE;
            ph    <= 1'b0;
            start <= 1'b0;
            dov   <= 1'b0;
            dch   <= 1'b0;
            orun  <= 1'b0;
        end else begin
            dov   <= 1'b0;
            start <= 1'b0;
            if (bus.div) begin
                if (state == IDLE) begin
                    if (bus.ce) begin
                        for (int i = NT - 1; i > 0; i--) dy[i] <= dy[i-1];
                        dy[0] <= bus.din;
                        ph    <= ~ph;
                        // Second y of a pair launches the computation next cycle
                        start <= ph;
                    end else begin
                        for (int i = NT - 1; i > 0; i--) dx[i] <= dx[i-1];
                        dx[0] <= bus.din;
                    end
                end else begin
                    orun <= 1'b1;
                end
            end
            unique case (state)
                IDLE:    if (start) state <= MX0;
                MX0:     state <= MX1;
                MX1:     state <= MX2;
                MX2:     state <= OX;
                OX: begin
                    state <= MY0;
                    dov   <= 1'b1;
                    dch   <= 1'b0;
                end
                MY0:     state <= MY1;
                MY1:     state <= MY2;
                MY2:     state <= OY;
                OY: begin
                    state <= IDLE;
                    dov   <= 1'b1;
                    dch   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        clr = 1'b0;
        en  = 1'b0;
        fin = 1'b0;
        chy = 1'b0;
        k   = 2'd0;
        unique case (state)
            MX0: clr = 1'b1;
            MX1: begin en = 1'b1; k = 2'd1; end
            MX2: begin en = 1'b1; k = 2'd2; end
            OX:  fin = 1'b1;
            MY0: begin clr = 1'b1; chy = 1'b1; end
            MY1: begin en = 1'b1; k = 2'd1; chy = 1'b1; end
            MY2: begin en = 1'b1; k = 2'd2; chy = 1'b1; end
            OY:  begin fin = 1'b1; chy = 1'b1; end
            default: ;
        endcase
    end

    // Symmetric tap pair d[2k], d[10-2k] of the channel being computed
    always_comb begin
        da = '0;
        db = '0;
        unique case (k)
            2'd0: begin
                da = chy ? dy[0] : dx[0];
                db = chy ? dy[10] : dx[10];
            end
            2'd1: begin
                da = chy ? dy[2] : dx[2];
                db = chy ? dy[8] : dx[8];
            end
            2'd2: begin
                da = chy ? dy[4] : dx[4];
                db = chy ? dy[6] : dx[6];
            end
            default: ;
        endcase
        dc = chy ? dy[5] : dx[5];
    end

    hbf_mac u_mac (
        .dclk (dclk),
        .rstn (rstn),
        .clr  (clr),
        .en   (en),
        .fin  (fin),
        .csel (k),
        .da   (da),
        .db   (db),
        .dc   (dc),
        .dout (dout),
        .ovf  (ovf)
    );

    assign bus.dout = dout;
    assign bus.dov  = dov;
    assign bus.dch  = dch;
    assign bus.ovf  = ovf;
    assign bus.orun = orun;

endmodule

// File: tb/tb_hbf_dec2x2.sv
// Bench for hbf_dec2x2: hand-derived vector table, corner sequences, random stream vs convolution model.
module tb_hbf_dec2x2;
    import hbf_pkg::*;

    logic dclk = 1'b0;
    logic rstn = 1'b0;

    hbf_dec2x2_if bus ();

    hbf_dec2x2 dut (
        .dclk (dclk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 dclk = ~dclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: direct convolution over sample histories, newest first
    typedef struct {
        bit     ch;
        longint val;
        bit     ovf;
        longint due;
    } exp_t;

    exp_t   expq[$];
    longint xh[$];
    longint yh[$];
    longint cyc = 0;
    longint busy_lo = -1;
    longint busy_hi = -1;
    bit     m_ph = 1'b0;
    bit     m_orun = 1'b0;
    longint hcoef [11] = '{1638, 0, -9830, 0, 40960, 65536, 40960, 0, -9830, 0, 1638};
    exp_t   ex_t;
    exp_t   ey_t;
    exp_t   got;

    function automatic void filt(input longint h[$], output longint v, output bit o);
        longint acc;
        acc = 0;
        for (int i = 0; i < h.size(); i++) acc += hcoef[i] * h[i];
        acc = (acc + 65536) >>> 17;
        o = 1'b1;
        if (acc > 131071) v = 131071;
        else if (acc < -131072) v = -131072;
        else begin
            v = acc;
            o = 1'b0;
        end
    endfunction

    always @(posedge dclk or negedge rstn) begin
        if (!rstn) begin
            xh.delete();
            yh.delete();
            expq.delete();
            m_ph = 1'b0;
            m_orun = 1'b0;
            busy_lo = -1;
            busy_hi = -1;
        end else begin
            cyc++;
            if (bus.div) begin
                if (cyc >= busy_lo && cyc <= busy_hi) begin
                    m_orun = 1'b1;
                end else if (!bus.ce) begin
                    xh.push_front(longint'(bus.din));
                    if (xh.size() > 11) void'(xh.pop_back());
                end else begin
                    yh.push_front(longint'(bus.din));
                    if (yh.size() > 11) void'(yh.pop_back());
                    if (m_ph) begin
                        ex_t.ch = 1'b0;
                        ex_t.due = cyc + 5;
                        filt(xh, ex_t.val, ex_t.ovf);
                        ey_t.ch = 1'b1;
                        ey_t.due = cyc + 9;
                        filt(yh, ey_t.val, ey_t.ovf);
                        expq.push_back(ex_t);
                        expq.push_back(ey_t);
                        busy_lo = cyc + 2;
                        busy_hi = cyc + 9;
                    end
                    m_ph = !m_ph;
                end
            end
        end
    end

    int     n_dov = 0;
    longint last_x = 0;
    longint last_y = 0;
    bit     last_ovfx = 1'b0;

    always @(negedge dclk) begin
        if (rstn) begin
            if (bus.dov) begin
                n_dov++;
                if (bus.dch) last_y = longint'(bus.dout);
                else begin
                    last_x = longint'(bus.dout);
                    last_ovfx = bus.ovf;
                end
                if (expq.size() == 0) begin
                    chk("unexpected_dov", 1, 0);
                end else begin
                    got = expq.pop_front();
                    chk("dch", longint'(bus.dch), longint'(got.ch));
                    chk("dout", longint'(bus.dout), got.val);
                    chk("ovf", longint'(bus.ovf), longint'(got.ovf));
                    chk("dov_cycle", cyc, got.due);
                end
            end else begin
                chk("ovf_idle", longint'(bus.ovf), 0);
                if (expq.size() > 0 && expq[0].due < cyc) begin
                    chk("missing_dov", cyc, expq[0].due);
                    void'(expq.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge dclk);
    endtask

    task automatic strobe(input bit ch, input longint v);
        bus.div = 1'b1;
        bus.ce  = ch;
        bus.din = DW'(v);
        @(negedge dclk);
        bus.div = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(2);
        last_x = -999999;
        last_y = -999999;
        last_ovfx = 1'b0;
    endtask

    typedef struct {
        bit rst;
        int x0;
        int x1;
        int y0;
        int y1;
        bit chk;
        int ex;
        int ey;
        bit eovf;
    } vec_t;

    function automatic vec_t mk(bit rst, int x0, int x1, int y0, int y1, bit c, int ex, int ey,
                                bit eo);
        vec_t v;
        v.rst = rst; v.x0 = x0; v.x1 = x1; v.y0 = y0; v.y1 = y1;
        v.chk = c; v.ex = ex; v.ey = ey; v.eovf = eo;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    vec_t   tbl[$];
    int     sq [11];
    int     n0;
    longint rv;
    int     sel;

    initial begin
        bus.din = '0;
        bus.div = 1'b0;
        bus.ce  = 1'b0;

        // Reset held while the input toggles
        rstn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge dclk);
            bus.div = i[0];
            bus.ce  = i[1];
            bus.din = 18'sd1234;
        end
        @(negedge dclk);
        bus.div = 1'b0;
        chk("rst_dout", longint'(bus.dout), 0);
        chk("rst_dov", longint'(bus.dov), 0);
        chk("rst_dch", longint'(bus.dch), 0);
        chk("rst_ovf", longint'(bus.ovf), 0);
        chk("rst_orun", longint'(bus.orun), 0);
        rstn = 1'b1;
        idle(2);
        n0 = n_dov;
        strobe(0, 1000); strobe(1, 2000);
        idle(12);
        chk("no_dov_first_y", n_dov - n0, 0);
        strobe(0, 3000); strobe(1, 4000);
        idle(12);
        chk("dov_second_y", n_dov - n0, 2);

        // Impulse on second x, impulse on first x, DC, saturation
        tbl.push_back(mk(1, 0, 100000, 0, 0, 1, 1250, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, -7500, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 31250, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 31250, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, -7500, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1250, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 100000, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 50000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(i == 0, 50000, 50000, -50000, -50000, i >= 5, 50000, -50000, 0));
        sq = '{131071, 0, -131072, 0, 131071, 131071, 131071, 0, -131072, 0, 131071};
        tbl.push_back(mk(1, 0, sq[0], 0, 0, 0, 0, 0, 0));
        for (int r = 1; r < 6; r++)
            tbl.push_back(mk(0, sq[2*r-1], sq[2*r], 0, 0, r == 5, 131071, 0, 1));

        foreach (tbl[r]) begin
            if (tbl[r].rst) do_reset();
            strobe(0, tbl[r].x0);
            strobe(1, tbl[r].y0);
            strobe(0, tbl[r].x1);
            strobe(1, tbl[r].y1);
            idle(12);
            if (tbl[r].chk) begin
                chk($sformatf("row%0d_x", r), last_x, tbl[r].ex);
                chk($sformatf("row%0d_y", r), last_y, tbl[r].ey);
                chk($sformatf("row%0d_ovfx", r), longint'(last_ovfx), longint'(tbl[r].eovf));
            end
        end

        // Overrun: x strobe lands in MX2 and must be dropped
        do_reset();
        strobe(0, 11111); strobe(1, 222); strobe(0, -3333); strobe(1, 444);
        idle(3);
        strobe(0, 77777);
        chk("orun_set", longint'(bus.orun), 1);
        idle(12);
        chk("orun_held", longint'(bus.orun), 1);
        strobe(0, 0); strobe(1, 0); strobe(0, 0); strobe(1, 0);
        idle(12);
        chk("ovr_next_x", last_x, 250);
        chk("orun_still", longint'(bus.orun), 1);

        // Reset pulse while in MY1 aborts the y result
        strobe(0, 60000); strobe(1, 5); strobe(0, 70000); strobe(1, 6);
        idle(6);
        rstn = 1'b0;
        #1;
        chk("abort_dout", longint'(bus.dout), 0);
        chk("abort_dov", longint'(bus.dov), 0);
        chk("abort_dch", longint'(bus.dch), 0);
        chk("abort_orun", longint'(bus.orun), 0);
        n0 = n_dov;
        idle(2);
        rstn = 1'b1;
        idle(14);
        chk("abort_no_dov", n_dov - n0, 0);

        // Random stream, including strobes that collide with a computation
        do_reset();
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0) rv = 131071;
            else if (sel == 1) rv = -131072;
            else rv = longint'($urandom_range(0, 262143)) - 131072;
            strobe(1'($urandom_range(0, 1)), rv);
            idle(int'($urandom_range(1, 12)));
        end
        idle(20);
        chk("orun_random", longint'(bus.orun), longint'(m_orun));
        chk("queue_drained", longint'(expq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
